// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: handshake bundle between the matrix sequencer and its
// environment (receive buffer, multiplier, transmitter).
//   i_recvd      receive buffer holds a complete 9-byte matrix (pulse)
//   o_load_a/b   capture buffer into matrix A / B (pulse)
//   o_mm_trigger start the multiplier (pulse)
//   i_mm_ready   multiplier result valid (level)
//   o_tx_start   request transmission of the result (level)
//   i_tx_busy    transmitter busy, asynchronous to the sequencer clock
//   o_state      current sequencer state, for debug/LEDs
//   o_overrun    sticky: matrix arrived while not waiting for one
//   o_abort      timeout abort (pulse)
// master = sequencer side, slave = environment side.
interface matmul_sequencer_if;
  logic       i_recvd;
  logic       o_load_a;
  logic       o_load_b;
  logic       o_mm_trigger;
  logic       i_mm_ready;
  logic       o_tx_start;
  logic       i_tx_busy;
  logic [2:0] o_state;
  logic       o_overrun;
  logic       o_abort;

  modport master (
    input  i_recvd, i_mm_ready, i_tx_busy,
    output o_load_a, o_load_b, o_mm_trigger, o_tx_start, o_state, o_overrun, o_abort
  );

  modport slave (
    output i_recvd, i_mm_ready, i_tx_busy,
    input  o_load_a, o_load_b, o_mm_trigger, o_tx_start, o_state, o_overrun, o_abort
  );
endinterface

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: collects matrix A then matrix B from the receive buffer,
// triggers the multiplier, waits for its result and hands it to the
// transmitter, then waits for the transmitter to finish.
// Ports:
//   i_clk  system clock, rising edge
//   i_rst  asynchronous active-high reset, release taken synchronously
//   bus    matmul_sequencer_if.master (see interface for signal list)
// Parameter TIMEOUT_CYCLES: MUL / TX_ACK abort limit, only used when the
// macro SEQ_TIMEOUT_EN is defined; otherwise no counter is built and o_abort
// is tied low.
module matmul_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  matmul_sequencer_if.master   bus
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    MUL     = 3'd2,
    TX_ACK  = 3'd3,
    TX_DONE = 3'd4
  } state_e;

  // Counter is 16 bits wide, so the limit must fit in it.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end

  state_e state_q, state_d;
  logic   load_a_q, load_a_d;
  logic   load_b_q, load_b_d;
  logic   trig_q, trig_d;
  logic   tx_start_q, tx_start_d;
  logic   overrun_q, overrun_d;
  logic   busy_meta_q, busy_meta_d;
  logic   busy_sync_q, busy_sync_d;
  logic   run_q, run_d;
`ifdef SEQ_TIMEOUT_EN
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    load_a_d    = 1'b0;
    load_b_d    = 1'b0;
    trig_d      = 1'b0;
    tx_start_d  = 1'b0;
    overrun_d   = overrun_q;
    busy_meta_d = bus.i_tx_busy;
    busy_sync_d = busy_meta_q;
    run_d       = 1'b1;
`ifdef SEQ_TIMEOUT_EN
    abort_d     = 1'b0;
    cnt_d       = '0;
`endif

    // run_q holds the FSM idle for the first edge after reset release.
    if (run_q) begin
      case (state_q)
        WAIT_A: begin
          if (bus.i_recvd) begin
            load_a_d = 1'b1;
            state_d  = WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.i_recvd) begin
            load_b_d = 1'b1;
            state_d  = MUL;
          end
        end
        MUL: begin
          // Trigger follows load_b; readiness before/at the trigger is stale.
          trig_d = load_b_q;
          if (bus.i_recvd) overrun_d = 1'b1;
          if (bus.i_mm_ready && !load_b_q && !trig_q) begin
            tx_start_d = 1'b1;
            state_d    = TX_ACK;
          end
        end
        TX_ACK: begin
          if (bus.i_recvd) overrun_d = 1'b1;
          if (busy_sync_q) begin
            state_d = TX_DONE;
          end else begin
            tx_start_d = 1'b1;
          end
        end
        TX_DONE: begin
          if (bus.i_recvd) overrun_d = 1'b1;
          if (!busy_sync_q) state_d = WAIT_A;
        end
        default: state_d = WAIT_A;
      endcase

`ifdef SEQ_TIMEOUT_EN
      // Counts while staying in MUL/TX_ACK; held clear through the first MUL cycle.
      if ((state_q == MUL || state_q == TX_ACK) && state_d == state_q && !load_b_q) begin
        if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          abort_d    = 1'b1;
          tx_start_d = 1'b0;
          state_d    = WAIT_A;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= WAIT_A;
      load_a_q    <= 1'b0;
      load_b_q    <= 1'b0;
      trig_q      <= 1'b0;
      tx_start_q  <= 1'b0;
      overrun_q   <= 1'b0;
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
      run_q       <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      abort_q     <= 1'b0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      load_a_q    <= load_a_d;
      load_b_q    <= load_b_d;
      trig_q      <= trig_d;
      tx_start_q  <= tx_start_d;
      overrun_q   <= overrun_d;
      busy_meta_q <= busy_meta_d;
      busy_sync_q <= busy_sync_d;
      run_q       <= run_d;
`ifdef SEQ_TIMEOUT_EN
      abort_q     <= abort_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.o_load_a     = load_a_q;
  assign bus.o_load_b     = load_b_q;
  assign bus.o_mm_trigger = trig_q;
  assign bus.o_tx_start   = tx_start_q;
  assign bus.o_state      = state_q;
  assign bus.o_overrun    = overrun_q;
`ifdef SEQ_TIMEOUT_EN
  assign bus.o_abort      = abort_q;
`else
  assign bus.o_abort      = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed-vector bench for matmul_sequencer.
module tb_matmul_sequencer;

  logic i_clk = 1'b0;
  logic i_rst;
  int   n_checks = 0;
  int   n_fail = 0;

  matmul_sequencer_if bus ();

  matmul_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic do_reset;
    bus.i_recvd = 1'b0; bus.i_mm_ready = 1'b0; bus.i_tx_busy = 1'b0;
    i_rst = 1'b1;
    cyc(2);
    i_rst = 1'b0;
    cyc(3);
  endtask

  task automatic pulse_recvd;
    bus.i_recvd = 1'b1;
    @(negedge i_clk);
    bus.i_recvd = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    bus.i_recvd = 1'b0; bus.i_mm_ready = 1'b0; bus.i_tx_busy = 1'b0;
    #1;
    n_checks++; if (bus.o_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.o_state); end
    n_checks++; if ({bus.o_load_a, bus.o_load_b, bus.o_mm_trigger, bus.o_tx_start, bus.o_overrun, bus.o_abort} !== 6'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b want 000000",
        {bus.o_load_a, bus.o_load_b, bus.o_mm_trigger, bus.o_tx_start, bus.o_overrun, bus.o_abort});
    end
    cyc(2);
    // i_recvd already high at release: first edge must not move the FSM
    bus.i_recvd = 1'b1;
    i_rst = 1'b0;
    @(negedge i_clk);
    n_checks++; if (bus.o_state !== 3'd0 || bus.o_load_a !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_sync: state %0d load_a %b want 0 0", bus.o_state, bus.o_load_a);
    end
    do_reset();
  endtask

  task automatic test_load_sequence;
    pulse_recvd();
    n_checks++; if (bus.o_load_a !== 1'b1 || bus.o_state !== 3'd1) begin
      n_fail++; $display("FAIL load_a_pulse: load_a %b state %0d want 1 1", bus.o_load_a, bus.o_state);
    end
    @(negedge i_clk);
    n_checks++; if (bus.o_load_a !== 1'b0 || bus.o_load_b !== 1'b0) begin
      n_fail++; $display("FAIL load_a_width: load_a %b load_b %b want 0 0", bus.o_load_a, bus.o_load_b);
    end
    cyc(8);
    pulse_recvd();
    n_checks++; if ({bus.o_load_b, bus.o_mm_trigger} !== 2'b10 || bus.o_state !== 3'd2) begin
      n_fail++; $display("FAIL load_b_pulse: load_b/trig %b state %0d want 10 2", {bus.o_load_b, bus.o_mm_trigger}, bus.o_state);
    end
    @(negedge i_clk);
    n_checks++; if ({bus.o_load_b, bus.o_mm_trigger} !== 2'b01 || bus.o_state !== 3'd2) begin
      n_fail++; $display("FAIL trigger_pulse: load_b/trig %b state %0d want 01 2", {bus.o_load_b, bus.o_mm_trigger}, bus.o_state);
    end
  endtask

  task automatic test_mul_tx;
    int k;
    cyc(5);
    n_checks++; if (bus.o_tx_start !== 1'b0 || bus.o_state !== 3'd2) begin
      n_fail++; $display("FAIL mul_wait: tx_start %b state %0d want 0 2", bus.o_tx_start, bus.o_state);
    end
    bus.i_mm_ready = 1'b1;
    @(negedge i_clk);
    n_checks++; if (bus.o_tx_start !== 1'b1 || bus.o_state !== 3'd3) begin
      n_fail++; $display("FAIL tx_start_rise: tx_start %b state %0d want 1 3", bus.o_tx_start, bus.o_state);
    end
    bus.i_mm_ready = 1'b0;
    bus.i_tx_busy = 1'b1;
    k = 0;
    while (k < 10) begin
      @(negedge i_clk);
      k++;
      if (bus.o_tx_start === 1'b0) break;
    end
    n_checks++; if (k < 2 || k > 3) begin n_fail++; $display("FAIL tx_start_fall: after %0d cycles want 2..3", k); end
    n_checks++; if (bus.o_state !== 3'd4) begin n_fail++; $display("FAIL tx_done_state: got %0d want 4", bus.o_state); end
    cyc(20);
    pulse_recvd();
    n_checks++; if (bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", bus.o_overrun); end
    n_checks++; if ({bus.o_load_a, bus.o_load_b, bus.o_mm_trigger} !== 3'b000 || bus.o_state !== 3'd4) begin
      n_fail++; $display("FAIL overrun_no_load: strobes %b state %0d want 000 4",
        {bus.o_load_a, bus.o_load_b, bus.o_mm_trigger}, bus.o_state);
    end
    cyc(75);
    bus.i_tx_busy = 1'b0;
    k = 0;
    while (k < 10) begin
      @(negedge i_clk);
      k++;
      if (bus.o_state === 3'd0) break;
    end
    n_checks++; if (k < 2 || k > 3) begin n_fail++; $display("FAIL return_wait_a: after %0d cycles want 2..3", k); end
    n_checks++; if (bus.o_overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", bus.o_overrun); end
  endtask

  task automatic test_reset_mid;
    int k;
    pulse_recvd();
    pulse_recvd();
    @(negedge i_clk);
    bus.i_mm_ready = 1'b1;
    k = 0;
    while (k < 10 && bus.o_tx_start !== 1'b1) begin
      @(negedge i_clk);
      k++;
    end
    n_checks++; if (bus.o_state !== 3'd3) begin n_fail++; $display("FAIL reach_tx_ack: got %0d want 3", bus.o_state); end
    cyc(2);
    #2 i_rst = 1'b1;
    #1;
    n_checks++; if (bus.o_tx_start !== 1'b0 || bus.o_state !== 3'd0 || bus.o_overrun !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: tx_start %b state %0d overrun %b want 0 0 0",
        bus.o_tx_start, bus.o_state, bus.o_overrun);
    end
    bus.i_mm_ready = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    cyc(3);
    pulse_recvd();
    n_checks++; if (bus.o_load_a !== 1'b1 || bus.o_state !== 3'd1) begin
      n_fail++; $display("FAIL reload_after_reset: load_a %b state %0d want 1 1", bus.o_load_a, bus.o_state);
    end
    do_reset();
  endtask

  task automatic test_stale_ready;
    bus.i_mm_ready = 1'b1;
    pulse_recvd();
    pulse_recvd();
    n_checks++; if (bus.o_load_b !== 1'b1 || bus.o_tx_start !== 1'b0) begin
      n_fail++; $display("FAIL stale_load_b: load_b %b tx_start %b want 1 0", bus.o_load_b, bus.o_tx_start);
    end
    @(negedge i_clk);
    n_checks++; if (bus.o_mm_trigger !== 1'b1 || bus.o_tx_start !== 1'b0) begin
      n_fail++; $display("FAIL stale_trigger: trig %b tx_start %b want 1 0", bus.o_mm_trigger, bus.o_tx_start);
    end
    @(negedge i_clk);
    n_checks++; if (bus.o_tx_start !== 1'b0 || bus.o_state !== 3'd2) begin
      n_fail++; $display("FAIL stale_no_skip: tx_start %b state %0d want 0 2", bus.o_tx_start, bus.o_state);
    end
    @(negedge i_clk);
    n_checks++; if (bus.o_tx_start !== 1'b1 || bus.o_state !== 3'd3) begin
      n_fail++; $display("FAIL stale_tx_start: tx_start %b state %0d want 1 3", bus.o_tx_start, bus.o_state);
    end
    do_reset();
  endtask

  task automatic test_held_recvd;
    bus.i_recvd = 1'b1;
    @(negedge i_clk);
    n_checks++; if ({bus.o_load_a, bus.o_load_b, bus.o_mm_trigger} !== 3'b100 || bus.o_state !== 3'd1) begin
      n_fail++; $display("FAIL held_load_a: strobes %b state %0d want 100 1", {bus.o_load_a, bus.o_load_b, bus.o_mm_trigger}, bus.o_state);
    end
    @(negedge i_clk);
    n_checks++; if ({bus.o_load_a, bus.o_load_b, bus.o_mm_trigger} !== 3'b010 || bus.o_state !== 3'd2) begin
      n_fail++; $display("FAIL held_load_b: strobes %b state %0d want 010 2", {bus.o_load_a, bus.o_load_b, bus.o_mm_trigger}, bus.o_state);
    end
    @(negedge i_clk);
    n_checks++; if ({bus.o_load_a, bus.o_load_b, bus.o_mm_trigger} !== 3'b001 || bus.o_overrun !== 1'b1) begin
      n_fail++; $display("FAIL held_overrun: strobes %b overrun %b want 001 1", {bus.o_load_a, bus.o_load_b, bus.o_mm_trigger}, bus.o_overrun);
    end
    cyc(2);
    n_checks++; if ({bus.o_load_a, bus.o_load_b, bus.o_mm_trigger} !== 3'b000 || bus.o_state !== 3'd2) begin
      n_fail++; $display("FAIL held_ignored: strobes %b state %0d want 000 2", {bus.o_load_a, bus.o_load_b, bus.o_mm_trigger}, bus.o_state);
    end
    bus.i_recvd = 1'b0;
    do_reset();
  endtask

  task automatic test_timeout;
    pulse_recvd();
    pulse_recvd();
    @(negedge i_clk);
`ifdef SEQ_TIMEOUT_EN
    begin
      int k;
      k = 0;
      while (k < 40) begin
        @(negedge i_clk);
        k++;
        if (bus.o_abort === 1'b1) break;
      end
      n_checks++; if (k != 16) begin n_fail++; $display("FAIL abort_timing: after %0d cycles want 16", k); end
      n_checks++; if (bus.o_state !== 3'd0 || bus.o_tx_start !== 1'b0) begin
        n_fail++; $display("FAIL abort_state: state %0d tx_start %b want 0 0", bus.o_state, bus.o_tx_start);
      end
    end
`else
    cyc(10000);
    n_checks++; if (bus.o_state !== 3'd2 || bus.o_abort !== 1'b0 || bus.o_tx_start !== 1'b0) begin
      n_fail++; $display("FAIL no_timeout: state %0d abort %b tx_start %b want 2 0 0", bus.o_state, bus.o_abort, bus.o_tx_start);
    end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_load_sequence();
    test_mul_tx();
    test_reset_mid();
    test_stale_ready();
    test_held_recvd();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/matmul_sequencer.md
MATMUL_SEQUENCER -- requirements
Module: matmul_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096: maximum i_clk cycles spent in MUL or TX_ACK before abort (used only with SEQ_TIMEOUT_EN).
REQ-002 i_clk  input  1  system clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset; asynchronous, active-high.
REQ-004 i_recvd  input  1  one-cycle pulse: the 9-byte matrix buffer holds a complete matrix.
REQ-005 o_load_a  output  1  one-cycle strobe: capture buffer contents into matrix A.
REQ-006 o_load_b  output  1  one-cycle strobe: capture buffer contents into matrix B.
REQ-007 o_mm_trigger  output  1  one-cycle strobe: start the multiplier.
REQ-008 i_mm_ready  input  1  level: multiplier result valid.
REQ-009 o_tx_start  output  1  level: request that the transmitter send the result.
REQ-010 i_tx_busy  input  1  transmitter busy, baud-clock domain, asynchronous to i_clk.
REQ-011 o_state  output  3  current state encoding, for debug and LEDs.
REQ-012 o_overrun  output  1  sticky: i_recvd arrived outside WAIT_A/WAIT_B.
REQ-013 o_abort  output  1  one-cycle pulse: timeout abort occurred.

Function
REQ-014 States (o_state encoding): WAIT_A=0, WAIT_B=1, MUL=2, TX_ACK=3, TX_DONE=4; values 5-7 are unreachable and return to WAIT_A on the next cycle.
REQ-015 WAIT_A: on i_recvd, pulse o_load_a in the same cycle and go to WAIT_B.
REQ-016 WAIT_B: on i_recvd, pulse o_load_b and go to MUL; o_mm_trigger pulses in the first MUL cycle, one cycle after o_load_b.
REQ-017 MUL: go to TX_ACK on the first cycle i_mm_ready is sampled high, where the trigger cycle itself does not count; o_tx_start rises on entry to TX_ACK.
REQ-018 TX_ACK: hold o_tx_start high until synchronized busy is 1, then deassert o_tx_start and go to TX_DONE.
REQ-019 TX_DONE: on the first cycle synchronized busy is 0, go to WAIT_A.
REQ-020 i_tx_busy passes through a 2-flop synchronizer before use; no other CDC paths exist.
REQ-021 i_recvd in MUL, TX_ACK or TX_DONE is ignored for loading and sets o_overrun, which stays set until reset.
REQ-022 All strobes are registered outputs; at most one of o_load_a, o_load_b or o_mm_trigger is high in any cycle.
REQ-023 i_recvd held high for several cycles produces one load per state entry only: WAIT_A then WAIT_B on consecutive cycles, then ignored with o_overrun set.
REQ-024 i_mm_ready already high on entry to MUL (stale) must not skip the trigger; readiness is sampled only after the trigger cycle.

Reset
REQ-025 Asserting i_rst immediately forces state=WAIT_A, all strobes=0, o_tx_start=0, o_overrun=0, o_abort=0, synchronizer flops=0 and timeout counter=0.
REQ-026 Reset mid-operation discards any progress; after release the block waits for a fresh matrix A.
REQ-027 Deassertion is taken synchronously: first transition no earlier than the second rising edge after release.

Configuration
REQ-028 Macro SEQ_TIMEOUT_EN defined: a 16-bit counter clears on entry to MUL and to TX_ACK and increments each cycle in those states.
REQ-029 With SEQ_TIMEOUT_EN, reaching TIMEOUT_CYCLES-1 without exit pulses o_abort, drops o_tx_start and forces WAIT_A.
REQ-030 SEQ_TIMEOUT_EN undefined: no counter is built, o_abort is tied 0, and MUL and TX_ACK wait indefinitely.

Verification
REQ-031 Two i_recvd pulses 10 cycles apart -> o_load_a at pulse 1, o_load_b at pulse 2, o_mm_trigger next cycle, o_state 0->1->2.
REQ-032 i_mm_ready high 5 cycles after trigger -> o_tx_start rises next cycle; i_tx_busy high for 100 cycles -> o_tx_start falls 2-3 cycles after rise; state returns to 0 2-3 cycles after busy falls.
REQ-033 i_recvd pulse during TX_DONE -> o_overrun=1, no load strobe, state flow unaffected.
REQ-034 i_rst asserted in TX_ACK -> o_tx_start=0 and state=0 without waiting for a clock edge; next i_recvd yields o_load_a.
REQ-035 SEQ_TIMEOUT_EN with TIMEOUT_CYCLES=16 and i_mm_ready held 0 -> o_abort pulse 16 cycles after trigger, state=0; without the macro, state stays at 2 after 10000 cycles.
REQ-036 i_mm_ready high before o_load_b -> trigger still issued and o_tx_start no earlier than 2 cycles after trigger.
